bar_collision_scorer: RTL and testbench

//  Consumer end of the bar-generator interface. Samples every bar's x_bar/y_gap/wraps plus bird_y.

---
 rtl/bar_collision_scorer.sv | 134 +++++++++++++
 tb/tb_bar_collision_scorer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bar_collision_scorer.sv
// Bird/bar collision detector, pass scorer and game FSM for the bar generators.
// Optional best-score register is built only when HIGH_SCORE_EN is defined.
module bar_collision_scorer #(
   parameter int NUM_BARS  = 2,
   parameter int BIRD_X    = 160,
   parameter int BIRD_W    = 20,
   parameter int BIRD_H    = 20,
   parameter int BAR_W     = 40,
   parameter int GAP_HALF  = 60,
   parameter int FLOOR_Y   = 480,
   parameter int SCORE_MAX = 999
) (
   input  logic                    clk_25MHz,
   input  logic                    reset,
   input  logic                    game_start,
   input  logic                    restart,
   input  logic [9:0]              bird_y,
   input  logic [10*NUM_BARS-1:0]  x_bar_flat,
   input  logic [9*NUM_BARS-1:0]   y_gap_flat,
   input  logic [NUM_BARS-1:0]     wraps,
   output logic                    lose,
   output logic [9:0]              score,
   output logic [9:0]              high_score
);

   typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DEAD} state_t;

   localparam logic signed [11:0] BX_LO = 12'(BIRD_X);
   localparam logic signed [11:0] BX_HI = 12'(BIRD_X + BIRD_W - 1);
   localparam logic signed [11:0] BAR_R = 12'(BAR_W - 1);
   localparam logic signed [11:0] GAP_H = 12'(GAP_HALF);
   localparam logic signed [11:0] GAP_T = 12'(GAP_HALF - 1);
   localparam logic signed [11:0] BH_M1 = 12'(BIRD_H - 1);
   localparam logic signed [11:0] BH    = 12'(BIRD_H);
   localparam logic signed [11:0] FLOOR = 12'(FLOOR_Y);

   state_t                state_q, state_d;
   logic [NUM_BARS-1:0]   hit1_d, hit1_p1_q;
   logic                  floor1_d, floor1_p1_q;
   logic                  hit_p2;
   logic [NUM_BARS-1:0]   passed_d, passed_q, pass;
   logic [9:0]            score_d, score_q;

   function automatic logic signed [11:0] ext10(input logic [9:0] v);
      return signed'({2'b00, v});
   endfunction

   function automatic logic bar_hit(input logic [9:0] x, input logic [8:0] g, input logic [9:0] by);
      logic signed [11:0] x_s, g_s, y_s, lo_s;
      logic               xov, out;
      x_s  = ext10(x);
      g_s  = signed'({3'b000, g});
      y_s  = ext10(by);
      lo_s = g_s - GAP_H;
      if (lo_s[11]) lo_s = '0;
      xov  = (x_s <= BX_HI) && (x_s + BAR_R >= BX_LO);
      out  = (y_s < lo_s) || (y_s + BH_M1 > g_s + GAP_T);
      return xov && out;
   endfunction

   function automatic logic [9:0] sat_add(input logic [9:0] a, input logic [NUM_BARS-1:0] p);
      logic [11:0] s;
      s = {2'b00, a};
      for (int i = 0; i < NUM_BARS; i++) s = s + {11'd0, p[i]};
      if (s > 12'(SCORE_MAX)) return 10'(SCORE_MAX);
      return s[9:0];
   endfunction

   always_comb begin
      state_d  = state_q;
      passed_d = passed_q;
      score_d  = score_q;
      pass     = '0;
      hit1_d   = '0;
      floor1_d = 1'b0;
      hit_p2   = (|hit1_p1_q) || floor1_p1_q;
      case (state_q)
         S_IDLE: if (game_start) state_d = S_PLAY;
         S_PLAY: begin
            // Stage 1 inputs, then pass detection; wraps beats a pass on the same bar
            for (int i = 0; i < NUM_BARS; i++) begin
               hit1_d[i] = bar_hit(x_bar_flat[10*i +: 10], y_gap_flat[9*i +: 9], bird_y);
               if (wraps[i]) begin
                  passed_d[i] = 1'b0;
               end else if ((ext10(x_bar_flat[10*i +: 10]) + BAR_R < BX_LO) && !passed_q[i]) begin
                  pass[i]     = 1'b1;
                  passed_d[i] = 1'b1;
               end
            end
            floor1_d = (ext10(bird_y) + BH > FLOOR);
            score_d  = sat_add(score_q, pass);
            if (hit_p2) state_d = S_DEAD;
         end
         S_DEAD: if (restart) begin
            state_d  = S_IDLE;
            score_d  = '0;
            passed_d = '0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Stage 1 flags registered here; the state register acts as stage 2
   always_ff @(posedge clk_25MHz) begin
      if (reset) begin
         state_q     <= S_IDLE;
         hit1_p1_q   <= '0;
         floor1_p1_q <= 1'b0;
         passed_q    <= '0;
         score_q     <= '0;
      end else begin
         state_q     <= state_d;
         hit1_p1_q   <= hit1_d;
         floor1_p1_q <= floor1_d;
         passed_q    <= passed_d;
         score_q     <= score_d;
      end
   end

`ifdef HIGH_SCORE_EN
   logic [9:0] high_q;
   always_ff @(posedge clk_25MHz) begin
      if (reset) high_q <= '0;
      else if (state_q == S_DEAD && restart && score_q > high_q) high_q <= score_q;
   end
   assign high_score = high_q;
`else
   assign high_score = 10'd0;
`endif

   assign lose  = (state_q == S_DEAD);
   assign score = score_q;

endmodule

// File: tb/tb_bar_collision_scorer.sv
// Directed plus random bench for bar_collision_scorer against a geometric game model;
// a second instance with SCORE_MAX=3 exercises saturation.
module tb_bar_collision_scorer;

   localparam int NB      = 2;
   localparam int BIRD_X  = 160;
   localparam int BIRD_W  = 20;
   localparam int BIRD_H  = 20;
   localparam int BAR_W   = 40;
   localparam int GAP_HALF = 60;
   localparam int FLOOR_Y = 480;
   localparam int MAX_A   = 999;
   localparam int MAX_B   = 3;

   logic             clk = 1'b0;
   logic             reset, game_start, restart;
   logic [9:0]       bird_y;
   logic [10*NB-1:0] x_bar_flat;
   logic [9*NB-1:0]  y_gap_flat;
   logic [NB-1:0]    wraps;
   logic             lose, lose_s;
   logic [9:0]       score, score_s, high_score, high_s;

   int errors = 0;
   int checks = 0;

   // model state: 0 idle, 1 play, 2 dead
   int m_state, m_score, m_score_s, m_high, m_high_s;
   bit m_coll;
   bit m_passed [NB];

   always #20 clk = ~clk;

   bar_collision_scorer dut (
      .clk_25MHz(clk), .reset(reset), .game_start(game_start), .restart(restart),
      .bird_y(bird_y), .x_bar_flat(x_bar_flat), .y_gap_flat(y_gap_flat), .wraps(wraps),
      .lose(lose), .score(score), .high_score(high_score));

   bar_collision_scorer #(.SCORE_MAX(MAX_B)) dut_sat (
      .clk_25MHz(clk), .reset(reset), .game_start(game_start), .restart(restart),
      .bird_y(bird_y), .x_bar_flat(x_bar_flat), .y_gap_flat(y_gap_flat), .wraps(wraps),
      .lose(lose_s), .score(score_s), .high_score(high_s));

   function automatic int bar_x(int i);
      return int'(x_bar_flat[10*i +: 10]);
   endfunction

   function automatic int bar_g(int i);
      return int'(y_gap_flat[9*i +: 9]);
   endfunction

   // Rectangle test: bird box vs. bar columns outside the gap, plus the floor
   function automatic bit collides();
      int by = int'(bird_y);
      bit c = (by + BIRD_H > FLOOR_Y);
      for (int i = 0; i < NB; i++) begin
         int x = bar_x(i);
         int g = bar_g(i);
         int lo = (g - GAP_HALF < 0) ? 0 : g - GAP_HALF;
         int hi = g + GAP_HALF - 1;
         bit ov = (x <= BIRD_X + BIRD_W - 1) && (x + BAR_W - 1 >= BIRD_X);
         bit outside = (by < lo) || (by + BIRD_H - 1 > hi);
         if (ov && outside) c = 1'b1;
      end
      return c;
   endfunction

   function automatic int imin(int a, int b);
      return (a < b) ? a : b;
   endfunction

   task automatic model_edge();
      if (reset) begin
         m_state = 0; m_score = 0; m_score_s = 0; m_high = 0; m_high_s = 0; m_coll = 1'b0;
         for (int i = 0; i < NB; i++) m_passed[i] = 1'b0;
      end else begin
         bit c = (m_state == 1) ? collides() : 1'b0;
         int cnt = 0;
         case (m_state)
            0: if (game_start) m_state = 1;
            1: begin
               for (int i = 0; i < NB; i++) begin
                  if (wraps[i]) m_passed[i] = 1'b0;
                  else if (bar_x(i) + BAR_W - 1 < BIRD_X && !m_passed[i]) begin
                     cnt++;
                     m_passed[i] = 1'b1;
                  end
               end
               m_score   = imin(m_score + cnt, MAX_A);
               m_score_s = imin(m_score_s + cnt, MAX_B);
               if (m_coll) m_state = 2;
            end
            default: if (restart) begin
               m_state = 0;
               if (m_score > m_high) m_high = m_score;
               if (m_score_s > m_high_s) m_high_s = m_score_s;
               m_score = 0; m_score_s = 0;
               for (int i = 0; i < NB; i++) m_passed[i] = 1'b0;
            end
         endcase
         m_coll = c;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int exp_high(int h);
`ifdef HIGH_SCORE_EN
      return h;
`else
      return 0 * h;
`endif
   endfunction

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("lose", {31'd0, lose}, (m_state == 2) ? 1 : 0);
      chk("score", {22'd0, score}, m_score);
      chk("high_score", {22'd0, high_score}, exp_high(m_high));
      chk("sat_lose", {31'd0, lose_s}, (m_state == 2) ? 1 : 0);
      chk("sat_score", {22'd0, score_s}, m_score_s);
      chk("sat_high", {22'd0, high_s}, exp_high(m_high_s));
   endtask

   task automatic set_bar(input int i, input int x, input int g);
      x_bar_flat[10*i +: 10] = 10'(x);
      y_gap_flat[9*i +: 9]   = 9'(g);
   endtask

   initial begin
      reset = 1'b1; game_start = 1'b0; restart = 1'b0; bird_y = 10'd230; wraps = '0;
      x_bar_flat = '0; y_gap_flat = '0;
      set_bar(0, 600, 240); set_bar(1, 600, 240);
      step(); step();
      chk("rst_lose", {31'd0, lose}, 0);
      chk("rst_score", {22'd0, score}, 0);
      chk("rst_high", {22'd0, high_score}, 0);
      reset = 1'b0;

      game_start = 1'b1; step(); game_start = 1'b0;
      set_bar(0, 150, 240);
      repeat (20) begin step(); chk("gap_clear_lose", {31'd0, lose}, 0); end

      bird_y = 10'd170;
      step(); chk("hit_lat1", {31'd0, lose}, 0);
      step(); chk("hit_lat2", {31'd0, lose}, 1);
      chk("hit_score_frozen", {22'd0, score}, 0);
      repeat (3) step();
      restart = 1'b1; step(); restart = 1'b0;
      chk("restart_lose", {31'd0, lose}, 0);
      bird_y = 10'd230; set_bar(0, 600, 240);

      game_start = 1'b1; step(); game_start = 1'b0;
      set_bar(0, 121, 240); step(); chk("pass_121", {22'd0, score}, 0);
      set_bar(0, 120, 240); step(); chk("pass_120", {22'd0, score}, 1);
      repeat (10) begin step(); chk("pass_hold", {22'd0, score}, 1); end
      wraps = 2'b01; step(); chk("wrap_cycle", {22'd0, score}, 1);
      wraps = 2'b00; step(); chk("repass", {22'd0, score}, 2);

      set_bar(0, 600, 240); bird_y = 10'd460;
      repeat (5) begin step(); chk("floor_460", {31'd0, lose}, 0); end
      bird_y = 10'd461;
      step(); chk("floor_461_lat1", {31'd0, lose}, 0);
      step(); chk("floor_461_lat2", {31'd0, lose}, 1);

      restart = 1'b1; step(); restart = 1'b0;
      chk("dead_idle_lose", {31'd0, lose}, 0);
      chk("dead_idle_score", {22'd0, score}, 0);
      chk("dead_idle_high", {22'd0, high_score}, exp_high(2));
      bird_y = 10'd230;

      game_start = 1'b1; step(); game_start = 1'b0;
      set_bar(0, 121, 240); set_bar(1, 121, 240); step();
      set_bar(0, 120, 240); set_bar(1, 120, 240); step();
      chk("double_pass", {22'd0, score}, 2);
      chk("double_pass_sat", {22'd0, score_s}, 2);
      wraps = 2'b11; step(); wraps = 2'b00; step();
      chk("second_double", {22'd0, score}, 4);
      chk("saturate", {22'd0, score_s}, 3);
      wraps = 2'b11; step(); wraps = 2'b00; step();
      chk("saturate_hold", {22'd0, score_s}, 3);

      reset = 1'b1; step(); reset = 1'b0;
      chk("midplay_rst_lose", {31'd0, lose}, 0);
      chk("midplay_rst_score", {22'd0, score}, 0);
      chk("midplay_rst_high", {22'd0, high_score}, 0);

      for (int n = 0; n < 2000; n++) begin
         reset      = ($urandom_range(0, 299) == 0);
         game_start = ($urandom_range(0, 7) == 0);
         restart    = ($urandom_range(0, 15) == 0);
         bird_y     = 10'($urandom_range(100, 470));
         for (int i = 0; i < NB; i++) begin
            set_bar(i, $urandom_range(0, 1023), $urandom_range(0, 511));
            wraps[i] = ($urandom_range(0, 3) == 0);
         end
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
